// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, field positions, opcodes and ALU function codes for cpu_core.
package cpu_pkg;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;
  localparam int OP_HI  = 15, OP_LO  = 12;
  localparam int RD_HI  = 11, RD_LO  = 9;
  localparam int RS1_HI = 8,  RS1_LO = 6;
  localparam int RS2_HI = 5,  RS2_LO = 3;
  localparam int FN_HI  = 2,  FN_LO  = 0;
  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BNE  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_LI   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef enum logic [2:0] {
    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLL, FN_SRL, FN_SLT
  } alu_fn_e;
endpackage

// File: rtl/cpu_decoder.sv
// decoder: opcode/funct to control strobes for the single-cycle datapath.
module decoder
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  input  logic [2:0] funct,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output alu_fn_e    alu_op,
  output logic       imm_sel,
  output logic       branch,
  output logic       jump,
  output logic       halt
);
  always_comb begin
    reg_write = op == OP_ALU || op == OP_ADDI || op == OP_LW || op == OP_LI;
    mem_read  = op == OP_LW;
    mem_write = op == OP_SW;
    alu_op    = op == OP_ALU ? alu_fn_e'(funct) : FN_ADD;
    imm_sel   = op == OP_ADDI || op == OP_LW || op == OP_SW;
    branch    = op == OP_BEQ || op == OP_BNE;
    jump      = op == OP_JMP;
    halt      = op == OP_HALT;
  end
endmodule

// File: rtl/cpu_register_file.sv
// register_file: 8x16 registers, two async read ports, one sync write port, r0 hardwired to zero.
module register_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] cpu_registers [0:NUM_REGS-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cpu_registers[i] <= '0;
    end else if (we && waddr != '0) begin
      cpu_registers[waddr] <= wdata;
    end
  end
  assign rdata_a = raddr_a == '0 ? '0 : cpu_registers[raddr_a];
  assign rdata_b = raddr_b == '0 ? '0 : cpu_registers[raddr_b];
endmodule

// File: rtl/cpu_core.sv
// cpu_core: single-cycle 16-bit Harvard core; ALU, immediates and next-PC inline.
module cpu_core
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Instruction,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] pc_addr_out,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_write,
  output logic              mem_write_enabled
);
  logic [DATA_W-1:0] pc_q, pc_d, pc_inc;
  logic [DATA_W-1:0] imm6, imm9, imm12;
  logic [DATA_W-1:0] ra, rb, alu_b, alu_y, wdata;
  logic [REG_AW-1:0] rd, rs1, rs2, raddr_b;
  logic [3:0] op;
  logic [2:0] funct;
  logic reg_write, mem_read, mem_write, imm_sel, branch, jump, halt, taken;
  alu_fn_e alu_op;
  assign op    = Instruction[OP_HI:OP_LO];
  assign rd    = Instruction[RD_HI:RD_LO];
  assign rs1   = Instruction[RS1_HI:RS1_LO];
  assign rs2   = Instruction[RS2_HI:RS2_LO];
  assign funct = Instruction[FN_HI:FN_LO];
  assign imm6  = {{10{Instruction[5]}}, Instruction[5:0]};
  assign imm9  = {{7{Instruction[8]}}, Instruction[8:0]};
  assign imm12 = {4'b0, Instruction[11:0]};
  decoder u_decoder (
    .op(op), .funct(funct), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .alu_op(alu_op), .imm_sel(imm_sel),
    .branch(branch), .jump(jump), .halt(halt)
  );
  // Stores and branches read rd through port B; ALU ops read rs2 there.
  assign raddr_b = mem_write || branch ? rd : rs2;
  register_file u_RegisterFile (
    .clk(clk), .rst(rst), .we(reg_write && !rst), .waddr(rd), .wdata(wdata),
    .raddr_a(rs1), .raddr_b(raddr_b), .rdata_a(ra), .rdata_b(rb)
  );
  assign alu_b = imm_sel ? imm6 : rb;
  always_comb begin
    case (alu_op)
      FN_ADD:  alu_y = ra + alu_b;
      FN_SUB:  alu_y = ra - alu_b;
      FN_AND:  alu_y = ra & alu_b;
      FN_OR:   alu_y = ra | alu_b;
      FN_XOR:  alu_y = ra ^ alu_b;
      FN_SLL:  alu_y = ra << alu_b[3:0];
      FN_SRL:  alu_y = ra >> alu_b[3:0];
      default: alu_y = {15'b0, $signed(ra) < $signed(alu_b)};
    endcase
  end
  always_comb begin
    wdata  = op == OP_LI ? imm9 : mem_read ? mem_data_in : alu_y;
    pc_inc = pc_q + 16'd1;
    taken  = branch && ((ra == rb) ^ op[0]);
    pc_d   = halt ? pc_q : jump ? imm12 : taken ? pc_inc + imm6 : pc_inc;
  end
  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end
  assign pc_addr_out       = pc_q;
  assign mem_addr          = mem_read || mem_write ? alu_y : '0;
  assign mem_data_write    = mem_write ? rb : '0;
  assign mem_write_enabled = mem_write && !rst;
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed programs with hand-computed register, PC and memory expectations.
module tb_cpu_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] rom  [0:255];
  logic [15:0] dmem [0:255];
  logic [15:0] Instruction, mem_data_in, pc_addr_out, mem_addr, mem_data_write;
  logic mem_write_enabled;
  int n_vec = 0;
  int n_err = 0;
  int we_cnt;
  cpu_core dut (
    .clk(clk), .rst(rst), .Instruction(Instruction), .mem_data_in(mem_data_in),
    .pc_addr_out(pc_addr_out), .mem_addr(mem_addr), .mem_data_write(mem_data_write),
    .mem_write_enabled(mem_write_enabled)
  );
  always #5 clk = ~clk;
  assign Instruction = rom[pc_addr_out[7:0]];
  assign mem_data_in = dmem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_write_enabled) dmem[mem_addr[7:0]] <= mem_data_write;
    if (rst) we_cnt <= 0;
    else if (mem_write_enabled) we_cnt <= we_cnt + 1;
  end
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] i_r(input logic [3:0] op, input logic [2:0] rd, rs1, rs2, fn);
    return {op, rd, rs1, rs2, fn};
  endfunction
  function automatic logic [15:0] i_i(input logic [3:0] op, input logic [2:0] rd, rs1, input logic [5:0] imm);
    return {op, rd, rs1, imm};
  endfunction
  function automatic logic [15:0] i_li(input logic [2:0] rd, input logic [8:0] imm);
    return {4'h7, rd, imm};
  endfunction
  function automatic logic [15:0] reg_of(input int i);
    return dut.u_RegisterFile.cpu_registers[i];
  endfunction
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask
  initial begin
    step(2);
    clear_rom();
    for (int i = 0; i < 256; i++) dmem[i] = 16'h0;
    dmem[0] = 16'd5;
    dmem[1] = 16'd3;
    rom[0] = i_i(4'h2, 3'd1, 3'd0, 6'd0);
    rom[1] = i_i(4'h2, 3'd2, 3'd0, 6'd1);
    rom[2] = i_r(4'h0, 3'd3, 3'd1, 3'd2, 3'd0);
    rom[3] = i_i(4'h3, 3'd3, 3'd0, 6'd2);
    do_reset();
    check("reset_pc", pc_addr_out, 16'd0);
    check("reset_r1", reg_of(1), 16'd0);
    check("lw_mem_read", {15'b0, dut.u_decoder.mem_read}, 16'd1);
    step(3);
    check("sw_addr", mem_addr, 16'd2);
    check("sw_data", mem_data_write, 16'd8);
    check("sw_we", {15'b0, mem_write_enabled}, 16'd1);
    check("add_mem_read", {15'b0, dut.u_decoder.mem_read}, 16'd0);
    step(1);
    check("mem2", dmem[2], 16'd8);
    check("r3_sum", reg_of(3), 16'd8);
    check("halt_pc", pc_addr_out, 16'd4);
    step(3);
    check("halt_hold", pc_addr_out, 16'd4);
    check("we_pulses", we_cnt[15:0], 16'd1);
    clear_rom();
    rom[0] = i_li(3'd1, 9'h1FF);
    rom[1] = i_i(4'h1, 3'd1, 3'd1, 6'd1);
    rom[2] = i_li(3'd1, 9'h1FF);
    rom[3] = i_r(4'h0, 3'd2, 3'd0, 3'd1, 3'd7);
    rom[4] = i_r(4'h0, 3'd3, 3'd0, 3'd1, 3'd1);
    rom[5] = i_r(4'h0, 3'd4, 3'd1, 3'd0, 3'd7);
    do_reset();
    step(1);
    check("li_neg", reg_of(1), 16'hFFFF);
    step(1);
    check("addi_wrap", reg_of(1), 16'h0000);
    step(2);
    check("slt_0_lt_m1", reg_of(2), 16'd0);
    step(1);
    check("sub_0_m1", reg_of(3), 16'd1);
    step(1);
    check("slt_m1_lt_0", reg_of(4), 16'd1);
    clear_rom();
    rom[0] = i_li(3'd4, 9'd5);
    rom[1] = i_li(3'd0, 9'd7);
    rom[2] = i_r(4'h0, 3'd4, 3'd0, 3'd0, 3'd0);
    do_reset();
    step(1);
    check("li_r4", reg_of(4), 16'd5);
    step(2);
    check("r0_kept", reg_of(0), 16'd0);
    check("r4_zero", reg_of(4), 16'd0);
    clear_rom();
    rom[0]  = i_li(3'd1, 9'd2);
    rom[1]  = i_li(3'd2, 9'd2);
    rom[2]  = i_i(4'h4, 3'd1, 3'd2, 6'd2);
    rom[3]  = i_li(3'd5, 9'd1);
    rom[4]  = i_li(3'd5, 9'd1);
    rom[5]  = i_i(4'h5, 3'd1, 3'd2, 6'd3);
    rom[6]  = {4'h6, 12'h00A};
    rom[10] = i_i(4'h5, 3'd1, 3'd0, 6'h3C);
    do_reset();
    step(2);
    check("pre_beq_pc", pc_addr_out, 16'd2);
    step(1);
    check("beq_taken", pc_addr_out, 16'd5);
    step(1);
    check("bne_fall", pc_addr_out, 16'd6);
    step(1);
    check("jmp", pc_addr_out, 16'd10);
    step(1);
    check("bne_back", pc_addr_out, 16'd7);
    step(1);
    check("halt_7", pc_addr_out, 16'd7);
    check("skipped_r5", reg_of(5), 16'd0);
    clear_rom();
    dmem[3] = 16'h1234;
    rom[0] = i_li(3'd1, 9'd9);
    rom[1] = i_i(4'h3, 3'd1, 3'd0, 6'd3);
    do_reset();
    step(1);
    rst = 1'b1;
    #1;
    check("rst_we_gate", {15'b0, mem_write_enabled}, 16'd0);
    step(1);
    rst = 1'b0;
    check("rst_no_store", dmem[3], 16'h1234);
    check("rst_mid_pc", pc_addr_out, 16'd0);
    check("rst_mid_r1", reg_of(1), 16'd0);
    step(2);
    check("store_after", dmem[3], 16'd9);
    clear_rom();
    rom[0] = i_li(3'd7, 9'h055);
    for (int i = 0; i < 7; i++) rom[i+1] = {4'(8 + i), 12'hE3F};
    do_reset();
    step(1);
    for (int i = 0; i < 7; i++) begin
      check("nop_addr", mem_addr, 16'd0);
      step(1);
      check("nop_pc", pc_addr_out, 16'(i + 2));
    end
    check("nop_r7", reg_of(7), 16'h0055);
    check("nop_r1", reg_of(1), 16'h0000);
    check("nop_we", we_cnt[15:0], 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
